// File: rtl/duv_mem_port_if.sv
// Request/response bus for the duv working-memory access port.
// The master side drives requests and consumes responses; the slave side is the port.
interface duv_mem_port_if #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              duv_mem_req_valid_ip;
  logic              duv_mem_req_ready_op;
  logic              duv_mem_req_write_ip;
  logic [ADDR_W-1:0] duv_mem_req_addr_ip;
  logic [DATA_W-1:0] duv_mem_req_wdata_ip;
  logic              duv_mem_rsp_valid_op;
  logic              duv_mem_rsp_ready_ip;
  logic              duv_mem_rsp_write_op;
  logic [DATA_W-1:0] duv_mem_rsp_rdata_op;
  logic [LVL_W-1:0]  duv_mem_level_op;
  logic [CNT_W-1:0]  duv_mem_rsp_cnt_op;
  logic [CNT_W-1:0]  duv_mem_stall_cnt_op;

  modport master (
    output duv_mem_req_valid_ip, duv_mem_req_write_ip, duv_mem_req_addr_ip,
           duv_mem_req_wdata_ip, duv_mem_rsp_ready_ip,
    input  duv_mem_req_ready_op, duv_mem_rsp_valid_op, duv_mem_rsp_write_op,
           duv_mem_rsp_rdata_op, duv_mem_level_op, duv_mem_rsp_cnt_op,
           duv_mem_stall_cnt_op
  );

  modport slave (
    input  duv_mem_req_valid_ip, duv_mem_req_write_ip, duv_mem_req_addr_ip,
           duv_mem_req_wdata_ip, duv_mem_rsp_ready_ip,
    output duv_mem_req_ready_op, duv_mem_rsp_valid_op, duv_mem_rsp_write_op,
           duv_mem_rsp_rdata_op, duv_mem_level_op, duv_mem_rsp_cnt_op,
           duv_mem_stall_cnt_op
  );
endinterface

// File: rtl/duv_mem_port.sv
// In-order request FIFO in front of a 2**ADDR_W x DATA_W memory, one service per cycle,
// with a single registered response stage under valid/ready backpressure.
module duv_mem_port #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic          duv_mem_clk_ip,
  input logic          duv_mem_rst_ip,
  duv_mem_port_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              fifo [FIFO_DEPTH];
  logic [DATA_W-1:0] mem  [2**ADDR_W];

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [LVL_W-1:0]  level;
  logic              rsp_valid, rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [CNT_W-1:0]  rsp_cnt, stall_cnt;

  req_t req, head;
  logic req_ready, push, pop, hs, stall;

  assign req       = {bus.duv_mem_req_write_ip, bus.duv_mem_req_addr_ip, bus.duv_mem_req_wdata_ip};
  assign head      = fifo[rd_ptr];
  // Ready looks only at level, so a full FIFO refuses even when it pops this cycle.
  assign req_ready = (level < LVL_W'(FIFO_DEPTH));
  assign push      = bus.duv_mem_req_valid_ip && req_ready;
  assign pop       = (level != '0) && (!rsp_valid || bus.duv_mem_rsp_ready_ip);
  assign hs        = rsp_valid && bus.duv_mem_rsp_ready_ip;
  assign stall     = bus.duv_mem_req_valid_ip && !req_ready;

  // Storage is deliberately unreset: memory contents survive a port reset.
  always_ff @(posedge duv_mem_clk_ip) begin
    if (push)              fifo[wr_ptr]   <= req;
    if (pop && head.write) mem[head.addr] <= head.wdata;
  end

  always_ff @(posedge duv_mem_clk_ip or negedge duv_mem_rst_ip) begin
    if (!duv_mem_rst_ip) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (pop) begin
        rsp_valid <= 1'b1;
        rsp_write <= head.write;
        rsp_rdata <= head.write ? '0 : mem[head.addr];
      end else if (hs) begin
        rsp_valid <= 1'b0;
      end
      if (hs) rsp_cnt <= rsp_cnt + CNT_W'(1);
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.duv_mem_req_ready_op = req_ready;
  assign bus.duv_mem_rsp_valid_op = rsp_valid;
  assign bus.duv_mem_rsp_write_op = rsp_write;
  assign bus.duv_mem_rsp_rdata_op = rsp_rdata;
  assign bus.duv_mem_level_op     = level;
  assign bus.duv_mem_rsp_cnt_op   = rsp_cnt;
  assign bus.duv_mem_stall_cnt_op = stall_cnt;
endmodule

// File: tb/tb_duv_mem_port.sv
// Directed bench for duv_mem_port: a default-size port plus an 8-bit-counter port
// used to reach stall-counter saturation in a short run.
module tb_duv_mem_port;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  duv_mem_port_if bus ();
  duv_mem_port_if #(.CNT_W(8)) sbus ();

  duv_mem_port u_dut (
    .duv_mem_clk_ip (clk),
    .duv_mem_rst_ip (rst_n),
    .bus            (bus)
  );

  duv_mem_port #(.CNT_W(8)) u_small (
    .duv_mem_clk_ip (clk),
    .duv_mem_rst_ip (rst_n),
    .bus            (sbus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.duv_mem_req_valid_ip = 1'b0;
    bus.duv_mem_req_write_ip = 1'b0;
    bus.duv_mem_req_addr_ip  = '0;
    bus.duv_mem_req_wdata_ip = '0;
  endtask

  // Present one request and return just after the edge that accepts it; valid is left high.
  task automatic send(input logic w, input logic [9:0] a, input logic [31:0] d);
    bit done = 1'b0;
    bus.duv_mem_req_valid_ip = 1'b1;
    bus.duv_mem_req_write_ip = w;
    bus.duv_mem_req_addr_ip  = a;
    bus.duv_mem_req_wdata_ip = d;
    for (int i = 0; i < 64 && !done; i++) begin
      if (bus.duv_mem_req_ready_op) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (bus.duv_mem_level_op == '0 && !bus.duv_mem_rsp_valid_op) ok = 1'b1;
      else tick();
    end
    check("drain", 64'(ok), 64'd1);
  endtask

  // Back-to-back requests at addr i mod 1024 (write data = addr); reads optionally
  // checked against data = addr, each appearing one edge after its acceptance.
  task automatic stream(input logic w, input int n, input bit chk, output int nbad);
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      bus.duv_mem_req_valid_ip = 1'b1;
      bus.duv_mem_req_write_ip = w;
      bus.duv_mem_req_addr_ip  = i[9:0];
      bus.duv_mem_req_wdata_ip = 32'(i[9:0]);
      if (!bus.duv_mem_req_ready_op) nbad++;
      tick();
      if (chk && i > 0 &&
          !(bus.duv_mem_rsp_valid_op && !bus.duv_mem_rsp_write_op &&
            bus.duv_mem_rsp_rdata_op == 32'((i - 1) % 1024)))
        nbad++;
    end
    idle();
    if (chk) begin
      tick();
      if (!(bus.duv_mem_rsp_valid_op && bus.duv_mem_rsp_rdata_op == 32'((n - 1) % 1024))) nbad++;
    end
  endtask

  initial begin
    int nbad;
    idle();
    bus.duv_mem_rsp_ready_ip  = 1'b1;
    sbus.duv_mem_req_valid_ip = 1'b0;
    sbus.duv_mem_req_write_ip = 1'b0;
    sbus.duv_mem_req_addr_ip  = '0;
    sbus.duv_mem_req_wdata_ip = '0;
    sbus.duv_mem_rsp_ready_ip = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    tick(); tick();
    check("rst_level",  64'(bus.duv_mem_level_op), 64'd0);
    check("rst_ready",  64'(bus.duv_mem_req_ready_op), 64'd1);
    check("rst_rvalid", 64'(bus.duv_mem_rsp_valid_op), 64'd0);
    check("rst_rwrite", 64'(bus.duv_mem_rsp_write_op), 64'd0);
    check("rst_rdata",  64'(bus.duv_mem_rsp_rdata_op), 64'd0);
    check("rst_rcnt",   64'(bus.duv_mem_rsp_cnt_op), 64'd0);
    check("rst_scnt",   64'(bus.duv_mem_stall_cnt_op), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Write then read 0x005: ack one edge after the write is accepted, then data
    send(1'b1, 10'h005, 32'hDEADBEEF);
    check("wr_level", 64'(bus.duv_mem_level_op), 64'd1);
    check("wr_no_rsp_yet", 64'(bus.duv_mem_rsp_valid_op), 64'd0);
    send(1'b0, 10'h005, 32'h0);
    check("ack_valid", 64'(bus.duv_mem_rsp_valid_op), 64'd1);
    check("ack_write", 64'(bus.duv_mem_rsp_write_op), 64'd1);
    check("ack_rdata", 64'(bus.duv_mem_rsp_rdata_op), 64'd0);
    idle();
    tick();
    check("rd_valid", 64'(bus.duv_mem_rsp_valid_op), 64'd1);
    check("rd_write", 64'(bus.duv_mem_rsp_write_op), 64'd0);
    check("rd_rdata", 64'(bus.duv_mem_rsp_rdata_op), 64'hDEADBEEF);
    check("rd_rcnt1", 64'(bus.duv_mem_rsp_cnt_op), 64'd1);
    tick();
    check("t1_rcnt", 64'(bus.duv_mem_rsp_cnt_op), 64'd2);
    check("t1_rvalid_clr", 64'(bus.duv_mem_rsp_valid_op), 64'd0);
    check("t1_rdata_hold", 64'(bus.duv_mem_rsp_rdata_op), 64'hDEADBEEF);

    // Backpressure: one request lands in the response stage, four fill the FIFO
    bus.duv_mem_rsp_ready_ip = 1'b0;
    bus.duv_mem_req_valid_ip = 1'b1;
    bus.duv_mem_req_write_ip = 1'b0;
    bus.duv_mem_req_addr_ip  = 10'h005;
    for (int i = 0; i < 5; i++) tick();
    check("bp_level", 64'(bus.duv_mem_level_op), 64'd4);
    check("bp_ready", 64'(bus.duv_mem_req_ready_op), 64'd0);
    check("bp_scnt0", 64'(bus.duv_mem_stall_cnt_op), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("bp_scnt",   64'(bus.duv_mem_stall_cnt_op), 64'(i));
      check("bp_stable", {31'd0, bus.duv_mem_rsp_valid_op, bus.duv_mem_rsp_write_op,
                          bus.duv_mem_rsp_rdata_op}, {31'd0, 2'b10, 32'hDEADBEEF});
      check("bp_hold_level", 64'(bus.duv_mem_level_op), 64'd4);
    end
    idle();
    bus.duv_mem_rsp_ready_ip = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      tick();
      check("bp_drain_level", 64'(bus.duv_mem_level_op), 64'(i));
      check("bp_drain_valid", 64'(bus.duv_mem_rsp_valid_op), 64'd1);
    end
    tick();
    check("bp_rcnt", 64'(bus.duv_mem_rsp_cnt_op), 64'd7);

    // Same-address ordering: ack, ack, then the latest data
    send(1'b1, 10'h3FF, 32'h1);
    send(1'b1, 10'h3FF, 32'h2);
    check("ord_ack1", {bus.duv_mem_rsp_valid_op, bus.duv_mem_rsp_write_op}, 64'b11);
    send(1'b0, 10'h3FF, 32'h0);
    check("ord_ack2", {bus.duv_mem_rsp_valid_op, bus.duv_mem_rsp_write_op}, 64'b11);
    idle();
    tick();
    check("ord_rdata", {bus.duv_mem_rsp_valid_op, bus.duv_mem_rsp_write_op,
                        bus.duv_mem_rsp_rdata_op}, {2'b10, 32'h2});
    drain();
    check("ord_rcnt", 64'(bus.duv_mem_rsp_cnt_op), 64'd10);

    // Full-memory stream: data = addr
    stream(1'b1, 1024, 1'b0, nbad);
    check("stream_wr_ready", 64'(nbad), 64'd0);
    stream(1'b0, 1024, 1'b1, nbad);
    check("stream_rd_data", 64'(nbad), 64'd0);
    drain();
    check("stream_rcnt", 64'(bus.duv_mem_rsp_cnt_op), 64'd2058);

    // Reset with a popped write in the response stage and two writes still queued
    bus.duv_mem_rsp_ready_ip = 1'b0;
    send(1'b1, 10'h100, 32'hA5A5A5A5);
    send(1'b1, 10'h101, 32'hBBBBBBBB);
    send(1'b1, 10'h102, 32'hCCCCCCCC);
    idle();
    check("mr_level_pre", 64'(bus.duv_mem_level_op), 64'd2);
    rst_n = 1'b0;
    #1;
    check("mr_level",  64'(bus.duv_mem_level_op), 64'd0);
    check("mr_rvalid", 64'(bus.duv_mem_rsp_valid_op), 64'd0);
    check("mr_rcnt",   64'(bus.duv_mem_rsp_cnt_op), 64'd0);
    check("mr_scnt",   64'(bus.duv_mem_stall_cnt_op), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.duv_mem_rsp_ready_ip = 1'b1;
    send(1'b0, 10'h100, 32'h0);
    idle();
    tick();
    check("mr_popped_write", 64'(bus.duv_mem_rsp_rdata_op), 64'hA5A5A5A5);
    send(1'b0, 10'h101, 32'h0);
    idle();
    tick();
    check("mr_dropped_write", 64'(bus.duv_mem_rsp_rdata_op), 64'h101);
    drain();
    check("mr_rcnt2", 64'(bus.duv_mem_rsp_cnt_op), 64'd2);

    // Response counter wrap
    stream(1'b0, 65533, 1'b0, nbad);
    check("wrap_ready", 64'(nbad), 64'd0);
    drain();
    check("wrap_ffff", 64'(bus.duv_mem_rsp_cnt_op), 64'hFFFF);
    send(1'b0, 10'h000, 32'h0);
    idle();
    drain();
    check("wrap_zero", 64'(bus.duv_mem_rsp_cnt_op), 64'h0);

    // Stall-counter saturation on the 8-bit instance
    sbus.duv_mem_req_valid_ip = 1'b1;
    for (int i = 0; i < 105; i++) tick();
    check("sat_mid", 64'(sbus.duv_mem_stall_cnt_op), 64'd100);
    check("sat_level", 64'(sbus.duv_mem_level_op), 64'd4);
    for (int i = 0; i < 200; i++) tick();
    check("sat_ff", 64'(sbus.duv_mem_stall_cnt_op), 64'hFF);
    sbus.duv_mem_req_valid_ip = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
